// File: rtl/sprite_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter_if
// Bundles the requester-side and ROM-side signals of the sprite ROM arbiter.
//
//   req       N_REQ         per-requester read request (level)
//   addr      N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       N_REQ         one-hot grant (combinational in the arbiter)
//   rom_en    1             ROM read enable
//   rom_addr  ADDR_W        ROM address
//   rom_data  DATA_W        ROM read data
//   rsp_valid N_REQ         one-hot response strobe
//   rsp_data  DATA_W        response word shared by all requesters
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (sprite units plus the ROM)
// ---------------------------------------------------------------------------
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic                    rom_en;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;

  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_en, rom_addr, rsp_valid, rsp_data
  );

  modport master (
    output req, addr, rom_data,
    input  gnt, rom_en, rom_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one synchronous-read sprite-sheet ROM between N_REQ sprite units.
// At most one request is accepted per cycle, forwarded to the ROM, and the
// returned word is routed back to the issuing requester with a one-hot strobe.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous, active-low reset
//   bus      slave modport of sprite_rom_arbiter_if
//            (req/addr/gnt to the requesters, rom_en/rom_addr/rom_data to the
//             ROM, rsp_valid/rsp_data back to the requesters)
//
// Parameters: N_REQ (2..8), ADDR_W, DATA_W, ROM_LAT (1..3).
//
// Build option: define SPRITE_ROM_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no rotating pointer). Default is round-robin.
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] k);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (k == PTR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Highest-priority index for the current search
  logic [PTR_W-1:0] ptr;

  // Grant search
  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    // Walk ptr, ptr+1, ... modulo N_REQ; first active request wins.
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!gnt_any && bus.req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign bus.gnt = gnt_any ? onehot(gnt_idx) : '0;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Address of the granted requester
  logic [ADDR_W-1:0] addr_sel;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) addr_sel = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Issue stage / tag pipeline / return stage
  logic                 rom_en_q,    rom_en_d;
  logic [ADDR_W-1:0]    rom_addr_q,  rom_addr_d;
  // Stage 0 is loaded together with rom_en; stage ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0]     tag_vld_q,   tag_vld_d;
  logic [PTR_W-1:0]     tag_idx_q [0:ROM_LAT];
  logic [PTR_W-1:0]     tag_idx_d [0:ROM_LAT];
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q,  rsp_data_d;

  always_comb begin
    rom_en_d    = gnt_any;
    rom_addr_d  = gnt_any ? addr_sel : rom_addr_q;

    tag_vld_d    = {tag_vld_q[ROM_LAT-1:0], gnt_any};
    tag_idx_d[0] = gnt_idx;
    for (int j = 1; j <= ROM_LAT; j++) begin
      tag_idx_d[j] = tag_idx_q[j-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[ROM_LAT]) begin
      rsp_valid_d = onehot(tag_idx_q[ROM_LAT]);
      rsp_data_d  = bus.rom_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      tag_vld_q   <= '0;
      for (int j = 0; j <= ROM_LAT; j++) tag_idx_q[j] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      tag_vld_q   <= tag_vld_d;
      for (int j = 0; j <= ROM_LAT; j++) tag_idx_q[j] <= tag_idx_d[j];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
// Directed bench: one arbiter with ROM_LAT=1 (b1/dut1) and one with
// ROM_LAT=3 (b3/dut3), each behind a behavioural ROM returning addr ^ 12'hFFF.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(12), .DATA_W(12)) b1 ();
  sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(12), .DATA_W(12)) b3 ();

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(12), .ROM_LAT(1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b1.slave)
  );

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(12), .DATA_W(12), .ROM_LAT(3)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b3.slave)
  );

  // ROM models
  always @(posedge clk) begin
    if (b1.rom_en) b1.rom_data <= b1.rom_addr ^ 12'hFFF;
  end

  logic [11:0] r3a, r3b;
  always @(posedge clk) begin
    if (b3.rom_en) r3a <= b3.rom_addr ^ 12'hFFF;
    r3b         <= r3a;
    b3.rom_data <= r3b;
  end

  int total = 0;
  int bad   = 0;

  // Addresses per requester and the hand-computed ROM words (addr ^ FFF)
  logic [11:0] addr_tab [4];
  logic [11:0] data_tab [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    addr_tab = '{12'h13C, 12'h23C, 12'h33C, 12'h43C};
    data_tab = '{12'hEC3, 12'hDC3, 12'hCC3, 12'hBC3};

    reset_n = 1'b0;
    b1.req  = '0;
    b3.req  = '0;
    b1.addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    b3.addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    to_next();

    // Reset state; gnt follows req even in reset, nothing is recorded
    b1.req = 4'b0010;
    to_neg();
    chk("rst_gnt", b1.gnt, 4'b0010);
    chk("rst_rom_en", b1.rom_en, 1'b0);
    chk("rst_rom_addr", b1.rom_addr, 12'h000);
    chk("rst_rsp_valid", b1.rsp_valid, 4'b0000);
    chk("rst_rsp_data", b1.rsp_data, 12'h000);
    to_next();
    to_neg();
    chk("rst_no_record", b1.rom_en, 1'b0);
    to_next();
    b1.req  = '0;
    reset_n = 1'b1;
    to_next();

    // Single request from index 2
    b1.addr[2*12 +: 12] = 12'h0A5;
    b1.req = 4'b0100;
    to_neg();
    chk("single_gnt", b1.gnt, 4'b0100);
    to_next();
    b1.req = '0;
    to_neg();
    chk("single_rom_en", b1.rom_en, 1'b1);
    chk("single_rom_addr", b1.rom_addr, 12'h0A5);
    chk("single_rsp_early1", b1.rsp_valid, 4'b0000);
    to_next();
    to_neg();
    chk("single_rsp_early2", b1.rsp_valid, 4'b0000);
    to_next();
    to_neg();
    chk("single_rsp_valid", b1.rsp_valid, 4'b0100);
    chk("single_rsp_data", b1.rsp_data, 12'hF5A);
    to_next();
    to_neg();
    chk("single_rsp_off", b1.rsp_valid, 4'b0000);
    chk("single_rsp_hold", b1.rsp_data, 12'hF5A);
    to_next();
    b1.addr[2*12 +: 12] = addr_tab[2];

    // Pointer wrap: grant 3, then req=1001 -> 0 then 3
    b1.req = 4'b1000;
    to_neg();
    chk("wrap_gnt3", b1.gnt, 4'b1000);
    to_next();
    b1.req = 4'b1001;
    to_neg();
    chk("wrap_gnt0", b1.gnt, 4'b0001);
    to_next();
    to_neg();
    chk("wrap_gnt_next", b1.gnt, FIXED ? 4'b0001 : 4'b1000);
    to_next();
    b1.req = '0;
    to_neg();
    chk("wrap_rsp3_valid", b1.rsp_valid, 4'b1000);
    chk("wrap_rsp3_data", b1.rsp_data, 12'hBC3);
    to_next();
    to_neg();
    chk("wrap_rsp0_valid", b1.rsp_valid, 4'b0001);
    chk("wrap_rsp0_data", b1.rsp_data, 12'hEC3);
    to_next();
    to_next();
    to_neg();
    chk("wrap_drained", b1.rsp_valid, 4'b0000);
    to_next();

    // All four requesting for 8 cycles from ptr=0
    for (int k = 0; k < 12; k++) begin
      b1.req = (k < 8) ? 4'b1111 : 4'b0000;
      to_neg();
      g = FIXED ? 0 : (k % 4);
      chk($sformatf("all_gnt_%0d", k), b1.gnt, (k < 8) ? (4'b0001 << g) : 4'b0000);
      if (k >= 1 && k <= 8) begin
        g = FIXED ? 0 : ((k - 1) % 4);
        chk($sformatf("all_rom_en_%0d", k), b1.rom_en, 1'b1);
        chk($sformatf("all_rom_addr_%0d", k), b1.rom_addr, addr_tab[g]);
      end
      if (k >= 3 && k <= 10) begin
        g = FIXED ? 0 : ((k - 3) % 4);
        chk($sformatf("all_rsp_valid_%0d", k), b1.rsp_valid, 4'b0001 << g);
        chk($sformatf("all_rsp_data_%0d", k), b1.rsp_data, data_tab[g]);
      end
      if (k == 11) chk("all_rsp_end", b1.rsp_valid, 4'b0000);
      to_next();
    end

    // req=0011 held for 4 cycles
    for (int k = 0; k < 4; k++) begin
      b1.req = 4'b0011;
      to_neg();
      chk($sformatf("pair_gnt_%0d", k), b1.gnt,
          (FIXED || (k % 2 == 0)) ? 4'b0001 : 4'b0010);
      to_next();
    end
    b1.req = '0;
    to_next();
    to_next();
    to_next();
    to_next();

    // Reset mid-flight: grant index 1, reset at T+1 for one cycle
    b1.req = 4'b0010;
    to_neg();
    chk("midrst_gnt", b1.gnt, 4'b0010);
    to_next();
    b1.req  = '0;
    reset_n = 1'b0;
    to_neg();
    chk("midrst_rom_en", b1.rom_en, 1'b0);
    chk("midrst_rsp_t1", b1.rsp_valid, 4'b0000);
    to_next();
    reset_n = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      to_neg();
      chk($sformatf("midrst_rsp_t%0d", k), b1.rsp_valid, 4'b0000);
      to_next();
    end
    b1.req = 4'b1111;
    to_neg();
    chk("midrst_ptr0", b1.gnt, 4'b0001);
    to_next();
    b1.req = '0;

    // ROM_LAT=3: back-to-back grants 2,3
    b3.req = 4'b0100;
    to_neg();
    chk("lat3_gnt2", b3.gnt, 4'b0100);
    to_next();
    b3.req = 4'b1000;
    to_neg();
    chk("lat3_gnt3", b3.gnt, 4'b1000);
    chk("lat3_rom_addr1", b3.rom_addr, 12'h33C);
    to_next();
    b3.req = '0;
    to_neg();
    chk("lat3_rom_addr2", b3.rom_addr, 12'h43C);
    to_next();
    to_next();
    to_neg();
    chk("lat3_rsp_t4", b3.rsp_valid, 4'b0000);
    to_next();
    to_neg();
    chk("lat3_rsp_t5_valid", b3.rsp_valid, 4'b0100);
    chk("lat3_rsp_t5_data", b3.rsp_data, 12'hCC3);
    to_next();
    to_neg();
    chk("lat3_rsp_t6_valid", b3.rsp_valid, 4'b1000);
    chk("lat3_rsp_t6_data", b3.rsp_data, 12'hBC3);
    to_next();
    to_neg();
    chk("lat3_rsp_t7", b3.rsp_valid, 4'b0000);
    to_next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous-read sprite-sheet ROM between up to N_REQ sprite units (yoshi, the three ghosts). Each cycle it accepts at most one request, forwards it to the ROM, and routes the returned pixel word back to the requester that issued it, tagged with a valid strobe. It sits in `display_top` between the sprite circuits and the shared ROM, in the `clk` domain.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, ROM address width
- DATA_W, 12, ROM word width (RGB 4:4:4)
- ROM_LAT, 1, ROM read latency in cycles, from `rom_en` to `rom_data` valid (1..3)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester read request, level
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational from `req` and the pointer
- rom_en  out  1  ROM read enable, registered
- rom_addr  out  ADDR_W  ROM address, registered
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  N_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_W  response word, registered, shared by all requesters

## Operation
- Handshake: a requester holds `req[i]` and its address stable until it sees `gnt[i]` high in the same cycle. The request is accepted on that rising edge. The requester may drop `req` or present a new address on the next cycle.
- Arbitration is round-robin. A pointer `ptr` (0..N_REQ-1) names the highest-priority index. The search runs ptr, ptr+1, …, wrapping mod N_REQ. The first requester found is granted.
- After a grant to index k, `ptr` ← (k+1) mod N_REQ. With no grant, `ptr` holds.
- `gnt` is 0 when `req` is 0. At most one `gnt` bit is high per cycle.
- Issue stage, on the edge after a grant to k:
  - `rom_en` ← 1
  - `rom_addr` ← addr[k]
  - tag ← k
- With no grant: `rom_en` ← 0 and `rom_addr` holds.
- Tag pipeline: a shift register of {valid, index} with depth ROM_LAT. It aligns each tag with its `rom_data`.
- Return stage: when the aligned tag is valid, on that edge `rsp_valid` ← onehot(tag) and `rsp_data` ← `rom_data`. Otherwise `rsp_valid` ← 0 and `rsp_data` holds.
- Throughput: one accepted request per cycle, sustained. Back-to-back grants are never stalled.

## Timing
- Grant accepted at edge T.
- `rom_en`/`rom_addr` are valid during cycle T+1.
- `rom_data` is valid during cycle T+1+ROM_LAT.
- `rsp_valid`/`rsp_data` are valid during cycle T+2+ROM_LAT. With ROM_LAT=1, the response is 3 cycles after grant.
- Responses return in grant order with no reordering.
- Reset values, asynchronous on `reset_n` low:
  - `ptr`=0
  - `rom_en`=0, `rom_addr`=0
  - all tag stages invalid
  - `rsp_valid`=0, `rsp_data`=0
- `gnt` follows `req` combinationally even while in reset, but no request is recorded while `reset_n` is low.
- Reset mid-operation discards all in-flight reads. No `rsp_valid` is produced for requests granted before reset.
- Simultaneous all-request case: grants rotate ptr, ptr+1, … and each requester is served once every N_REQ cycles.
- The requester granted at k is never granted again before every other continuously-requesting index has been served once.

## Configuration
- SPRITE_ROM_ARB_FIXED_PRIO_EN defined:
  - fixed priority, lowest index wins
  - `ptr` is removed (constant 0)
  - a starving index is permitted
- Undefined (default): round-robin as specified above.

## Test plan
- Reset then single request: N_REQ=4, ROM_LAT=1, req=4'b0100, addr[2]=12'h0A5, ROM returns addr^12'hFFF.
  - gnt=4'b0100 in the same cycle
  - rom_addr=12'h0A5 next cycle
  - rsp_valid=4'b0100 with rsp_data=12'hF5A three cycles after the grant
- All four request continuously for 8 cycles from ptr=0:
  - grant sequence 0,1,2,3,0,1,2,3
  - eight responses in the same order, one per cycle, no gaps
- Pointer wrap: grant index 3, then req=4'b1001.
  - next grant is index 0 (ptr wrapped to 0)
  - then index 3
- Reset mid-flight: grant index 1, then pull reset_n low at T+1 for one cycle.
  - no rsp_valid in cycles T+2..T+6
  - ptr=0 after release
- ROM_LAT=3 build with back-to-back grants 2,3.
  - rsp_valid=4'b0100 at T+5, 4'b1000 at T+6, with matching data
- SPRITE_ROM_ARB_FIXED_PRIO_EN build with req=4'b0011 held for 4 cycles: gnt=4'b0001 every cycle and index 1 is never granted.
